// File: rtl/orb_lb_pkg.sv
// Shared geometry constants for the ORB front end.
// The line buffer picks up its defaults from here.
package orb_lb_pkg;

  localparam int unsigned IMG_W    = 577;
  localparam int unsigned PIX_W    = 8;
  localparam int unsigned WIN_ROWS = 7;

endpackage

// File: rtl/lb_ram.sv
// One line-delay stage: simple dual-port RAM.
// Reads are synchronous and read-before-write; the read register holds while re_i is low.
module lb_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 577
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Only the read register is reset; the array keeps stale content.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/line_buffer_taps.sv
// Multi-row line buffer presenting NUM_TAPS vertically aligned pixels per enabled sample,
// with per-tap validity for the current frame.
module line_buffer_taps
  import orb_lb_pkg::*;
#(
  parameter int unsigned DATA_W   = PIX_W,
  parameter int unsigned LINE_W   = IMG_W,
  parameter int unsigned NUM_TAPS = WIN_ROWS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         sof,
  input  logic [DATA_W-1:0]            din,
  output logic [NUM_TAPS*DATA_W-1:0]   taps,
  output logic [NUM_TAPS-1:0]          tap_mask,
  output logic                         taps_vld,
  output logic [$clog2(LINE_W)-1:0]    col_out,
  output logic                         eol_out
);

  localparam int unsigned CW = $clog2(LINE_W);
  localparam int unsigned RW = $clog2(NUM_TAPS + 1);
  localparam logic [CW-1:0] LastCol = CW'(LINE_W - 1);
  localparam logic [RW-1:0] MaxRows = RW'(NUM_TAPS);

  logic [CW-1:0]       ptr_q, ptr_d, addr;
  logic [RW-1:0]       rows_q, rows_d, rows_eff;
  logic [NUM_TAPS-1:0] mask_d;
  logic [DATA_W-1:0]   din_q;

  always_comb begin
    addr     = sof ? '0 : ptr_q;
    rows_eff = sof ? '0 : rows_q;
    ptr_d    = ptr_q;
    rows_d   = rows_q;
    mask_d   = '0;
    if (en) begin
      ptr_d = (addr == LastCol) ? '0 : addr + 1'b1;
      if (sof) begin
        rows_d = '0;
      end else if (ptr_q == LastCol && rows_q != MaxRows) begin
        rows_d = rows_q + 1'b1;
      end
    end
    for (int k = 0; k < NUM_TAPS; k++) begin
      mask_d[k] = (int'(rows_eff) > k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      rows_q   <= '0;
      tap_mask <= '0;
      taps_vld <= 1'b0;
      col_out  <= '0;
      eol_out  <= 1'b0;
      din_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rows_q   <= rows_d;
      taps_vld <= en;
      eol_out  <= en && (addr == LastCol);
      if (en) begin
        tap_mask <= mask_d;
        col_out  <= addr;
        din_q    <= din;
      end
    end
  end

  // Writes land one cycle after the sample, at that sample's column, so stage k can take
  // stage k-1's registered read data; the column is not revisited for LINE_W samples.
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_stage
    logic [DATA_W-1:0] wdata;
    if (k == 0) begin : g_first
      assign wdata = din_q;
    end else begin : g_chain
      assign wdata = taps[(k-1)*DATA_W +: DATA_W];
    end

    lb_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (LINE_W)
    ) u_ram (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .re_i    (en),
      .raddr_i (addr),
      .rdata_o (taps[k*DATA_W +: DATA_W]),
      .we_i    (taps_vld),
      .waddr_i (col_out),
      .wdata_i (wdata)
    );
  end

endmodule

// File: tb/tb_line_buffer_taps.sv
// Directed bench for line_buffer_taps: small config (8,4,3) plus a default-parameter instance.
module tb_line_buffer_taps;

  localparam int DW = 8;
  localparam int LW = 4;
  localparam int NT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic              en = 1'b0, sof = 1'b0;
  logic [DW-1:0]     din = '0;
  logic [NT*DW-1:0]  taps;
  logic [NT-1:0]     tap_mask;
  logic              taps_vld, eol_out;
  logic [1:0]        col_out;

  logic              en2 = 1'b0, sof2 = 1'b0;
  logic [7:0]        din2 = '0;
  logic [7*8-1:0]    taps2;
  logic [6:0]        mask2;
  logic              vld2, eol2;
  logic [9:0]        col2;

  int n_cmp = 0;
  int n_err = 0;

  line_buffer_taps #(.DATA_W(DW), .LINE_W(LW), .NUM_TAPS(NT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sof(sof), .din(din), .taps(taps),
    .tap_mask(tap_mask), .taps_vld(taps_vld), .col_out(col_out), .eol_out(eol_out)
  );

  line_buffer_taps dflt (
    .clk(clk), .rst_n(rst_n), .en(en2), .sof(sof2), .din(din2), .taps(taps2),
    .tap_mask(mask2), .taps_vld(vld2), .col_out(col2), .eol_out(eol2)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running, need done");
    $fatal(1, "timeout");
  end

  function automatic logic [DW-1:0] tap(input int k);
    return taps[k*DW +: DW];
  endfunction

  function automatic logic [NT-1:0] exp_mask(input int row);
    if (row >= NT) return '1;
    return NT'((1 << row) - 1);
  endfunction

  task automatic drive(input logic e, input logic s, input logic [DW-1:0] d);
    @(negedge clk);
    en = e; sof = s; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if (taps !== '0) begin n_err++; $display("FAIL reset_taps got %h need 0", taps); end
    n_cmp++; if (tap_mask !== '0) begin n_err++; $display("FAIL reset_mask got %b need 0", tap_mask); end
    n_cmp++; if (taps_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got %b need 0", taps_vld); end
    n_cmp++; if (col_out !== '0) begin n_err++; $display("FAIL reset_col got %0d need 0", col_out); end
    n_cmp++; if (eol_out !== 1'b0) begin n_err++; $display("FAIL reset_eol got %b need 0", eol_out); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 16; i++) begin
      int row;
      row = (i - 1) / LW;
      drive(1'b1, i == 1, DW'(i));
      n_cmp++; if (taps_vld !== 1'b1) begin n_err++; $display("FAIL fill_vld i=%0d got %b need 1", i, taps_vld); end
      n_cmp++; if (col_out !== 2'((i - 1) % LW)) begin n_err++; $display("FAIL fill_col i=%0d got %0d need %0d", i, col_out, (i - 1) % LW); end
      n_cmp++; if (eol_out !== (((i - 1) % LW) == LW - 1)) begin n_err++; $display("FAIL fill_eol i=%0d got %b", i, eol_out); end
      n_cmp++; if (tap_mask !== exp_mask(row)) begin n_err++; $display("FAIL fill_mask i=%0d got %b need %b", i, tap_mask, exp_mask(row)); end
      for (int k = 0; k < NT; k++) begin
        if (row > k) begin
          n_cmp++;
          if (tap(k) !== DW'(i - (k + 1) * LW)) begin
            n_err++; $display("FAIL fill_tap%0d i=%0d got %0d need %0d", k, i, tap(k), i - (k + 1) * LW);
          end
        end
      end
      if (i == 13) begin
        n_cmp++;
        if (taps !== {8'd1, 8'd5, 8'd9} || tap_mask !== 3'b111 || col_out !== 2'd0) begin
          n_err++; $display("FAIL sample13 got taps=%h mask=%b col=%0d need 010509 111 0", taps, tap_mask, col_out);
        end
      end
    end
    // Idle cycle with sof asserted: everything holds, sof ignored.
    drive(1'b0, 1'b1, 8'd99);
    n_cmp++; if (taps_vld !== 1'b0 || eol_out !== 1'b0) begin n_err++; $display("FAIL idle_vld_eol got %b%b need 00", taps_vld, eol_out); end
    n_cmp++; if (taps !== {8'd4, 8'd8, 8'd12}) begin n_err++; $display("FAIL idle_taps got %h need 04080c", taps); end
    n_cmp++; if (col_out !== 2'd3 || tap_mask !== 3'b111) begin n_err++; $display("FAIL idle_hold got col=%0d mask=%b need 3 111", col_out, tap_mask); end
    drive(1'b1, 1'b0, 8'd17);
    n_cmp++; if (col_out !== 2'd0 || taps !== {8'd5, 8'd9, 8'd13}) begin
      n_err++; $display("FAIL sof_ignored got col=%0d taps=%h need 0 05090d", col_out, taps);
    end
    drive(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_random_gaps;
    int lens [3] = '{20, 14, 23};
    for (int f = 0; f < 3; f++) begin
      logic [DW-1:0] hist [32];
      for (int n = 0; n < lens[f]; n++) begin
        int idle;
        logic [DW-1:0] v;
        idle = 0;
        while (idle < 3 && $urandom_range(0, 1) == 1) idle++;
        for (int g = 0; g <= idle; g++) begin
          int m;
          logic e;
          e = (g == idle);
          if (e) begin
            v = DW'($urandom_range(0, 255));
            hist[n] = v;
            drive(1'b1, n == 0, v);
          end else begin
            drive(1'b0, 1'b0, DW'($urandom_range(0, 255)));
          end
          if (!e && n == 0) continue;
          m = e ? n : n - 1;
          n_cmp++;
          if (taps_vld !== e || eol_out !== (e && (m % LW) == LW - 1)) begin
            n_err++; $display("FAIL gap_vld f=%0d n=%0d got vld=%b eol=%b", f, n, taps_vld, eol_out);
          end
          n_cmp++;
          if (col_out !== 2'(m % LW) || tap_mask !== exp_mask(m / LW)) begin
            n_err++; $display("FAIL gap_pos f=%0d n=%0d got col=%0d mask=%b need %0d %b", f, n, col_out, tap_mask, m % LW, exp_mask(m / LW));
          end
          for (int k = 0; k < NT; k++) begin
            if (m / LW > k) begin
              n_cmp++;
              if (tap(k) !== hist[m - (k + 1) * LW]) begin
                n_err++; $display("FAIL gap_tap%0d f=%0d n=%0d got %0d need %0d", k, f, m, tap(k), hist[m - (k + 1) * LW]);
              end
            end
          end
        end
      end
    end
    drive(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_sof_midline;
    for (int i = 0; i < LW + 2; i++) drive(1'b1, i == 0, DW'(100 + i));
    drive(1'b1, 1'b1, 8'd200);
    n_cmp++; if (col_out !== 2'd0 || tap_mask !== 3'b000 || taps_vld !== 1'b1) begin
      n_err++; $display("FAIL midsof got col=%0d mask=%b vld=%b need 0 000 1", col_out, tap_mask, taps_vld);
    end
    for (int i = 1; i < LW; i++) drive(1'b1, 1'b0, DW'(200 + i));
    n_cmp++; if (tap_mask !== 3'b000 || col_out !== 2'd3) begin
      n_err++; $display("FAIL midsof_row0 got mask=%b col=%0d need 000 3", tap_mask, col_out);
    end
    drive(1'b1, 1'b0, 8'd204);
    n_cmp++; if (tap(0) !== 8'd200 || tap_mask !== 3'b001 || col_out !== 2'd0) begin
      n_err++; $display("FAIL midsof_tap0 got tap0=%0d mask=%b col=%0d need 200 001 0", tap(0), tap_mask, col_out);
    end
    drive(1'b1, 1'b0, 8'd205);
    n_cmp++; if (tap(0) !== 8'd201) begin n_err++; $display("FAIL midsof_tap0b got %0d need 201", tap(0)); end
    drive(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 2 * LW + 2; i++) drive(1'b1, i == 0, DW'(50 + i));
    n_cmp++; if (tap_mask !== 3'b011 || col_out !== 2'd1) begin
      n_err++; $display("FAIL prereset got mask=%b col=%0d need 011 1", tap_mask, col_out);
    end
    @(negedge clk);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (taps !== '0 || tap_mask !== '0 || col_out !== '0 || taps_vld !== 1'b0 || eol_out !== 1'b0) begin
      n_err++; $display("FAIL async_reset got taps=%h mask=%b col=%0d vld=%b eol=%b need all 0", taps, tap_mask, col_out, taps_vld, eol_out);
    end
    @(negedge clk); rst_n = 1'b1;
    drive(1'b1, 1'b0, 8'd77);
    n_cmp++; if (col_out !== 2'd0 || tap_mask !== 3'b000 || taps_vld !== 1'b1) begin
      n_err++; $display("FAIL post_reset got col=%0d mask=%b vld=%b need 0 000 1", col_out, tap_mask, taps_vld);
    end
    for (int i = 1; i < LW; i++) drive(1'b1, 1'b0, DW'(77 + i));
    n_cmp++; if (col_out !== 2'd3 || eol_out !== 1'b1 || tap_mask !== 3'b000) begin
      n_err++; $display("FAIL post_reset_eol got col=%0d eol=%b mask=%b need 3 1 000", col_out, eol_out, tap_mask);
    end
    drive(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_default_params;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 577; c++) begin
        @(negedge clk);
        en2 = 1'b1; sof2 = (r == 0 && c == 0); din2 = 8'(r * 5 + c);
        @(posedge clk);
        #1;
        if (r == 7 && (c == 0 || c == 1 || c == 288 || c == 576)) begin
          n_cmp++;
          if (taps2[6*8 +: 8] !== 8'(c) || taps2[7:0] !== 8'(30 + c)) begin
            n_err++; $display("FAIL dflt_taps c=%0d got tap6=%0d tap0=%0d need %0d %0d", c, taps2[6*8 +: 8], taps2[7:0], c & 255, (30 + c) & 255);
          end
          n_cmp++;
          if (mask2 !== 7'h7F || col2 !== 10'(c) || eol2 !== (c == 576)) begin
            n_err++; $display("FAIL dflt_pos c=%0d got mask=%h col=%0d eol=%b", c, mask2, col2, eol2);
          end
        end
      end
    end
    @(negedge clk); en2 = 1'b0; sof2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_random_gaps();
    test_sof_midline();
    test_async_reset();
    test_default_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
